// File: rtl/mips32_ctrl_pkg.sv
// Shared encodings for the mips32 multi-cycle controller: states, opcodes,
// datapath mux selects and the decoded instruction class.
package mips32_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_WB_R     = 4'd11,
        S_WB_I     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    localparam logic [1:0] PCS_INC    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // zext marks logical immediates (andi/ori) that need a zero-extended operand
    typedef struct packed {
        logic rtype;
        logic mem_load;
        logic mem_store;
        logic branch;
        logic jump;
        logic imm;
        logic zext;
        logic halt;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/mips32_ctrl_decode.sv
// Combinational opcode classifier feeding the DECODE transition and EXEC_I
// operand select.
module mips32_ctrl_decode
    import mips32_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic [5:0]   opcode_i,
    output instr_class_t cls_o
);

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OP_RTYPE:         cls_o.rtype     = 1'b1;
            OP_LW:            cls_o.mem_load  = 1'b1;
            OP_SW:            cls_o.mem_store = 1'b1;
            OP_BEQ, OP_BNE:   cls_o.branch    = 1'b1;
            OP_J:             cls_o.jump      = 1'b1;
            OP_ADDI, OP_SLTI: cls_o.imm       = 1'b1;
            OP_ANDI, OP_ORI: begin
                cls_o.imm  = 1'b1;
                cls_o.zext = 1'b1;
            end
            default: begin
                if (opcode_i == HALT_OPCODE) cls_o.halt    = 1'b1;
                else                         cls_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips32_multicycle_ctrl.sv
// Multi-cycle control FSM for the mips32 datapath: shared memory port with
// ready handshake, per-state strobes, retired-instruction counter, halt status.
module mips32_multicycle_ctrl
    import mips32_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             halted,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    logic             illegal_q;
    logic [CNT_W-1:0] instr_count_q;
    instr_class_t     cls;

    mips32_ctrl_decode #(.HALT_OPCODE(HALT_OPCODE)) u_decode (
        .opcode_i (opcode),
        .cls_o    (cls)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE:     if (start) state_q <= S_FETCH;
                S_FETCH:    if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if (cls.rtype)                         state_q <= S_EXEC_R;
                    else if (cls.mem_load | cls.mem_store) state_q <= S_MEM_ADDR;
                    else if (cls.branch)                   state_q <= S_BRANCH;
                    else if (cls.jump)                     state_q <= S_JUMP;
                    else if (cls.imm)                      state_q <= S_EXEC_I;
                    else if (cls.halt)                     state_q <= S_HALT;
                    else if (cls.illegal) begin
                        state_q   <= S_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC_R:   state_q <= S_WB_R;
                S_EXEC_I:   state_q <= S_WB_I;
                S_MEM_ADDR: state_q <= cls.mem_load ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
                S_MEM_WR: begin
                    if (mem_ready) begin
                        state_q       <= S_FETCH;
                        instr_count_q <= instr_count_q + CNT_W'(1);
                    end
                end
                // final cycle of every retiring instruction returns to FETCH
                S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: begin
                    state_q       <= S_FETCH;
                    instr_count_q <= instr_count_q + CNT_W'(1);
                end
                S_HALT:     state_q <= S_HALT;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PCS_INC;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = SRCB_SEXT;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_IMM;
                alu_src_b = cls.zext ? SRCB_ZEXT : SRCB_SEXT;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = PCS_BRANCH;
                pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCS_JUMP;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_WB_I:     reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Trace-driven bench: each instruction expands into its expected per-cycle
// state sequence; a compare process checks every cycle against that trace.
module tb_mips32_multicycle_ctrl;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3,
                   ST_EXEC_I = 4, ST_MEM_ADDR = 5, ST_MEM_RD = 6, ST_MEM_WB = 7,
                   ST_MEM_WR = 8, ST_BRANCH = 9, ST_JUMP = 10, ST_WB_R = 11,
                   ST_WB_I = 12, ST_HALT = 13;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_write, pc_write, alu_src_a, mem_read, mem_write, i_or_d;
    logic        mem_to_reg, reg_write, reg_dst, halted, illegal;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] instr_count;
    logic [14:0] dut_ctrl;

    mips32_multicycle_ctrl #(.CNT_W(32), .HALT_OPCODE(6'b111111)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode),
        .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write),
        .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .reg_dst(reg_dst), .halted(halted),
        .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    assign dut_ctrl = {ir_write, pc_write, pc_source, alu_src_a, alu_src_b, alu_op,
                       mem_read, mem_write, i_or_d, mem_to_reg, reg_write, reg_dst};

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 0;
    int          exp_st = 0;
    logic [14:0] exp_ctrl = '0;
    int unsigned m_cnt = 0;
    bit          m_ill = 0;
    bit          lit_on = 0;
    int unsigned lit_cnt = 0;
    bit          lit_halt = 0;
    bit          lit_ill = 0;

    function automatic bit rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    // Strobe table straight from the per-state rules.
    function automatic logic [14:0] ref_ctrl(int st, logic [5:0] op, bit rdy, bit z);
        logic irw, pcw, sa, mr, mw, iod, m2r, rw, rd;
        logic [1:0] pcs, sb, aop;
        {irw, pcw, sa, mr, mw, iod, m2r, rw, rd} = '0;
        pcs = 2'b00; sb = 2'b00; aop = 2'b00;
        case (st)
            ST_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            ST_DECODE:   sb = 2'b10;
            ST_EXEC_R:   begin sa = 1; aop = 2'b10; end
            ST_EXEC_I:   begin sa = 1; aop = 2'b11;
                               sb = (op == 6'b001100 || op == 6'b001101) ? 2'b11 : 2'b10; end
            ST_MEM_ADDR: begin sa = 1; sb = 2'b10; end
            ST_MEM_RD:   begin mr = 1; iod = 1; end
            ST_MEM_WB:   begin rw = 1; m2r = 1; end
            ST_MEM_WR:   begin mw = 1; iod = 1; end
            ST_BRANCH:   begin sa = 1; aop = 2'b01; pcs = 2'b01;
                               pcw = (op == 6'b000100 && z) || (op == 6'b000101 && !z); end
            ST_JUMP:     begin pcw = 1; pcs = 2'b10; end
            ST_WB_R:     begin rw = 1; rd = 1; end
            ST_WB_I:     rw = 1;
            default: ;
        endcase
        return {irw, pcw, pcs, sa, sb, aop, mr, mw, iod, m2r, rw, rd};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (chk_en) begin
            check("state", 64'(state), 64'(exp_st));
            check("ctrl", 64'(dut_ctrl), 64'(exp_ctrl));
            check("halted", 64'(halted), 64'(exp_st == ST_HALT));
            check("illegal", 64'(illegal), 64'(m_ill));
            check("instr_count", 64'(instr_count), 64'(m_cnt));
        end
        if (lit_on) begin
            check("pin_count", 64'(instr_count), 64'(lit_cnt));
            check("pin_halted", 64'(halted), 64'(lit_halt));
            check("pin_illegal", 64'(illegal), 64'(lit_ill));
        end
    end

    task automatic cycle(input int st, input bit rdy, input bit z, input bit strt,
                         input logic [5:0] op, input bit rst = 0);
        @(negedge clock);
        reset = rst; mem_ready = rdy; zero = z; start = strt; opcode = op;
        chk_en = !rst;
        exp_st = st;
        exp_ctrl = ref_ctrl(st, op, rdy, z);
        #3;
        lit_on = 0;
    endtask

    task automatic pin(input int unsigned c, input bit h, input bit il);
        lit_cnt = c; lit_halt = h; lit_ill = il; lit_on = 1;
    endtask

    task automatic do_reset();
        cycle(ST_IDLE, rb(), rb(), rb(), rnd6(), 1);
        cycle(ST_IDLE, rb(), rb(), rb(), rnd6(), 1);
        m_cnt = 0;
        m_ill = 0;
    endtask

    task automatic go();
        cycle(ST_IDLE, rb(), rb(), 0, rnd6());
        cycle(ST_IDLE, rb(), rb(), 1, rnd6());
    endtask

    // Expands one instruction into its cycle trace; fw/mw are memory wait cycles.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z);
        for (int i = 0; i < fw; i++) cycle(ST_FETCH, 0, rb(), rb(), rnd6());
        cycle(ST_FETCH, 1, rb(), rb(), rnd6());
        cycle(ST_DECODE, rb(), rb(), rb(), op);
        case (op)
            6'b000000: begin
                cycle(ST_EXEC_R, rb(), rb(), rb(), op);
                cycle(ST_WB_R, rb(), rb(), rb(), op);
                m_cnt++;
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                cycle(ST_EXEC_I, rb(), rb(), rb(), op);
                cycle(ST_WB_I, rb(), rb(), rb(), op);
                m_cnt++;
            end
            6'b100011: begin
                cycle(ST_MEM_ADDR, rb(), rb(), rb(), op);
                for (int i = 0; i < mw; i++) cycle(ST_MEM_RD, 0, rb(), rb(), op);
                cycle(ST_MEM_RD, 1, rb(), rb(), op);
                cycle(ST_MEM_WB, rb(), rb(), rb(), op);
                m_cnt++;
            end
            6'b101011: begin
                cycle(ST_MEM_ADDR, rb(), rb(), rb(), op);
                for (int i = 0; i < mw; i++) cycle(ST_MEM_WR, 0, rb(), rb(), op);
                cycle(ST_MEM_WR, 1, rb(), rb(), op);
                m_cnt++;
            end
            6'b000100, 6'b000101: begin
                cycle(ST_BRANCH, rb(), z, rb(), op);
                m_cnt++;
            end
            6'b000010: begin
                cycle(ST_JUMP, rb(), rb(), rb(), op);
                m_cnt++;
            end
            default: begin
                if (op != 6'b111111) m_ill = 1;
                for (int i = 0; i < 10; i++) cycle(ST_HALT, rb(), rb(), 1, op);
            end
        endcase
    endtask

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                   6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

    initial begin
        do_reset();
        go();
        run_instr(6'b000000, 0, 0, 0);
        pin(1, 0, 0);
        run_instr(6'b100011, 0, 3, 0);
        run_instr(6'b000100, 0, 0, 1);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000101, 0, 0, 0);
        run_instr(6'b000101, 1, 0, 1);
        run_instr(6'b010101, 0, 0, 0);
        pin(6, 1, 1);
        cycle(ST_HALT, rb(), rb(), 1, 6'b010101);
        do_reset();
        pin(0, 0, 0);
        cycle(ST_IDLE, 0, 0, 0, 6'b000000);

        // reset in the middle of a stalled store
        cycle(ST_IDLE, 0, 0, 1, 6'b000000);
        cycle(ST_FETCH, 1, 0, 0, rnd6());
        cycle(ST_DECODE, 0, 0, 0, 6'b101011);
        cycle(ST_MEM_ADDR, 0, 0, 0, 6'b101011);
        cycle(ST_MEM_WR, 0, 0, 0, 6'b101011);
        cycle(ST_MEM_WR, 0, 0, 0, 6'b101011, 1);
        m_cnt = 0; m_ill = 0;
        pin(0, 0, 0);
        cycle(ST_IDLE, 0, 0, 0, 6'b101011);

        go();
        run_instr(6'b001000, 0, 0, 0);
        run_instr(6'b001101, 1, 0, 0);
        run_instr(6'b101011, 0, 2, 0);
        run_instr(6'b000010, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 0);
        pin(4, 1, 0);
        cycle(ST_HALT, rb(), rb(), 1, 6'b111111);

        do_reset();
        go();
        for (int n = 0; n < 200; n++) begin
            run_instr(legal_ops[$urandom_range(9, 0)], $urandom_range(2, 0),
                      ($urandom_range(3, 0) == 0) ? $urandom_range(4, 1) : 0, rb());
        end
        run_instr(rb() ? 6'b111111 : 6'b110011, 0, 0, 0);

        chk_en = 0;
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips32_multicycle_ctrl.md
Name: mips32_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the mips32 datapath (pc register, register block, ALU, instruction and data memory). One shared memory port is used for fetch and data access, with a ready handshake. Per-state control strobes drive the datapath muxes and write enables. The block also provides a retired-instruction counter and a halt/illegal status for the testbench.

Parameters:
CNT_W, 32, width of instr_count.
HALT_OPCODE, 6'b111111, opcode that stops execution.

Ports:
clock  in  1  single system clock; all state updates on posedge.
reset  in  1  synchronous, active-high.
start  in  1  leave IDLE and begin fetching.
opcode  in  6  instruction[31:26] from instruction register.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory port completes access this cycle.
ir_write  out  1  load instruction register.
pc_write  out  1  load PC.
pc_source  out  2  00 ALU result (pc+1), 01 ALUOut (branch target), 10 jump target.
alu_src_a  out  1  0 PC, 1 read_data_1.
alu_src_b  out  2  00 read_data_2, 01 constant 1, 10 sign-extended imm, 11 zero-extended imm.
alu_op  out  2  00 add, 01 sub, 10 funct field, 11 opcode-derived (immediate ops).
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
i_or_d  out  1  0 address = PC, 1 address = ALUOut.
mem_to_reg  out  1  write-back source: 1 memory data, 0 ALUOut.
reg_write  out  1  register block write enable.
reg_dst  out  1  0 rt, 1 rd.
halted  out  1  in HALT state.
illegal  out  1  halt caused by an unknown opcode.
state  out  4  current state encoding, for debug.
instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset: state=IDLE; all strobes 0; halted=0; illegal=0; instr_count=0. Reset applied mid-instruction aborts it at that edge. No write strobe is asserted in the cycle after reset.
- Control outputs are combinational from state. pc_write additionally depends on zero and mem_ready, as noted below.
- States (encoding): IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_RD 6, MEM_WB 7, MEM_WR 8, BRANCH 9, JUMP 10, WB_R 11, WB_I 12, HALT 13.
- IDLE: all strobes 0. Go to FETCH when start=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - While mem_ready=0: stay in FETCH; ir_write=0; pc_write=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_source=00, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (ALUOut ← PC+1+imm, word addressing). Next state by opcode:
  - 000000 → EXEC_R
  - 100011 (lw), 101011 (sw) → MEM_ADDR
  - 000100 (beq), 000101 (bne) → BRANCH
  - 000010 (j) → JUMP
  - 001000, 001100, 001101, 001010 (addi, andi, ori, slti) → EXEC_I
  - HALT_OPCODE → HALT
  - anything else → HALT with illegal set to 1.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Go to WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- EXEC_I: alu_src_a=1, alu_op=11; alu_src_b=11 for andi/ori, 10 otherwise. Go to WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready=1, then go to FETCH. mem_write stays asserted while waiting.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_write = (beq & zero) | (bne & ~zero). Go to FETCH.
- JUMP: pc_write=1, pc_source=10. Go to FETCH.
- HALT: halted=1; all strobes 0; terminal until reset. start is ignored.
- opcode is sampled from the instruction register, so it is stable from DECODE to the end of the instruction.
- instr_count increments by 1 on each transition into FETCH from WB_R, WB_I, MEM_WB, MEM_WR, BRANCH or JUMP. It does not increment on IDLE→FETCH or on HALT. It wraps modulo 2^CNT_W.
- Latency in cycles with mem_ready=1, counted from FETCH entry to the next FETCH entry: R-type 4, imm ALU 4, lw 5, sw 4, beq/bne 3, j 3. Each memory wait cycle adds 1 cycle.

Decomposition:
- Package mips32_ctrl_pkg holds:
  - state enum/localparams;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI);
  - alu_op, alu_src_b and pc_source encodings.
- One sub-module, mips32_ctrl_decode: combinational opcode → instruction class (rtype, mem_load, mem_store, branch, jump, imm, halt, illegal), used by the DECODE transition and EXEC_I.

Test Plan:
- reset=1 for 2 cycles, then start=1 with mem_ready=1 and opcode=000000 → states 0,1,2,3,11,1; reg_write=1 and reg_dst=1 only in WB_R; instr_count=1.
- lw (100011) with mem_ready held 0 for 3 cycles in MEM_RD → mem_read and i_or_d=1 held for 4 cycles; MEM_WB asserts reg_write=1 and mem_to_reg=1; 8 cycles FETCH→FETCH.
- beq with zero=1, then beq with zero=0 → pc_write=1 then 0 in BRANCH, pc_source=01 in both; bne with zero=0 → pc_write=1.
- opcode 010101 in DECODE → HALT, halted=1, illegal=1, strobes 0 for 10 cycles despite start=1; reset → state=0, illegal=0.
- reset asserted while in MEM_WR with mem_ready=0 → next cycle state=IDLE, mem_write=0, instr_count=0.
- 5 instructions run (addi, ori, sw, j, then HALT_OPCODE) → instr_count=4 at halt, halted=1, ori uses alu_src_b=11, addi uses 10.
